apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Round-robin arbiter that shares the single `APB_Master` command port (`transfer`/`write`/`addr`/`wdata` in, `ready`/`rdata` out) between up to four requesters, such as the CPU bus bridge and a DMA engine. It accepts one command at a time, issues the single-cycle `transfer` strobe the master expects, and waits for the master's `ready`. It then returns read data and a completion pulse to the owning requester. It sits between the requesters and `APB_Master`; the slaves behind the master (`RAM`, `APB_Slave`) are untouched.

## Interface
- `NUM_REQ`, 2 — number of requesters; legal range 2..4.
- `PCLK` in 1 — clock; all state updates on rising edge.
- `PRESET` in 1 — reset; synchronous and active-high.
- `req` in NUM_REQ — per-requester command valid, level-held until that requester's `done` bit.
- `req_write` in NUM_REQ — per-requester 1 = write, 0 = read.
- `req_addr` in 32*NUM_REQ — packed addresses; requester i occupies bits [32i+31:32i].
- `req_wdata` in 32*NUM_REQ — packed write data, same packing.
- `done` out NUM_REQ — one-cycle completion pulse to the owning requester.
- `req_rdata` out 32*NUM_REQ — packed read data, updated only for the owner at completion.
- `busy` out 1 — high while a command is owned (ISSUE or WAIT).
- `transfer` out 1 — one-cycle start strobe to `APB_Master`.
- `write` out 1 — command direction to the master.
- `addr` out 32 — command address to the master.
- `wdata` out 32 — command write data to the master.
- `ready` in 1 — master completion (PREADY in access phase).
- `rdata` in 32 — master read data, valid while `ready` = 1.

## Operation
- FSM states:
  - IDLE: at a clock edge with any eligible `req`, select the winner. Latch `write`/`addr`/`wdata` from the winner's slice, record the owner index, and go to ISSUE.
  - ISSUE: `transfer` = 1 for exactly this cycle; next state WAIT.
  - WAIT: at an edge with `ready` = 1:
    - if the command was a read, copy `rdata` into the owner's `req_rdata` slice;
    - set the owner's `done` bit for one cycle;
    - set `last_grant` to the owner;
    - go to IDLE.
- Eligibility: requester i is eligible when `req[i]` = 1 and `done[i]` = 0. The `done` mask prevents re-granting a requester in the cycle it is being told of completion.
- Arbitration: rotating priority. Search begins at `(last_grant+1) mod NUM_REQ` and increments modulo NUM_REQ; the first eligible requester wins. `last_grant` resets to NUM_REQ-1, so requester 0 wins the first tie.
- Non-preemptive: requests arriving during ISSUE/WAIT are not sampled. A request deasserted mid-transaction has no effect on the owned command.
- `write`, `addr` and `wdata` hold their latched values from ISSUE until the next grant. They are not cleared on return to IDLE.
- Write completion leaves `req_rdata` unchanged. Other requesters' `req_rdata` slices never change except at their own completion.
- `ready` is ignored in IDLE and ISSUE. A stray `ready` there causes no state change.
- `busy` = (state != IDLE), decoded from state.

## Timing
- Reset values: state IDLE, `transfer` 0, `write` 0, `addr` 0, `wdata` 0, `done` all 0, `req_rdata` all 0, `busy` 0, `last_grant` NUM_REQ-1.
- `PRESET` mid-transaction: return to IDLE next edge, all outputs to reset values, no `done` emitted. System-level reset of `APB_Master` is required alongside.
- Grant latency: `req` sampled high at edge k → `transfer` high from edge k to edge k+1.
- Completion latency: `ready` sampled high at edge m → `done`/`req_rdata` valid from edge m to edge m+1. The arbiter is in IDLE during that cycle.
- Minimum command period is 3 cycles plus slave wait states; back-to-back grants have one IDLE cycle between `done` and the next `transfer`.
- Requester contract: hold `req`, `req_write`, `req_addr` and `req_wdata` stable until `done`. To issue a new command, drop `req` or keep it high with new fields in the cycle after `done`.
- Simultaneous `done[i]` and new `req[j]` (j≠i): j is granted at that edge.

## Test plan
- Reset: hold `PRESET`=1 for 2 cycles with `req`=2'b11 → `transfer`, `done` and `busy` stay 0 and all outputs are at their reset values.
- Single write: requester 0 writes 32'h1000_0004 ← 32'd2 → `transfer` is one cycle with `addr`=32'h1000_0004, `wdata`=2, `write`=1. `done[0]` pulses one cycle after `ready`. Reading the same address back through requester 0 returns `req_rdata[31:0]`=2.
- Round-robin: both requesters hold `req` continuously. Requester 0 writes 32'h1000_0000 ← 1, requester 1 writes 32'h1000_1000 ← 11. Grants alternate 0,1,0,1 and `done[1]`'s slice is never written by requester 0's completions.
- Cross-slave read: requester 1 reads 32'h1000_3000 after a write of 32'd100 → `req_rdata[63:32]`=100 and `req_rdata[31:0]` is unchanged.
- Stray/late `ready`: force `ready`=1 in IDLE → no `done`. Hold slave wait states for 5 cycles → `transfer` stays 0 and `busy` stays 1 until `ready`.
- Reset mid-WAIT: assert `PRESET` while `busy`=1 → IDLE next edge, no `done` pulse. The next request is granted to requester 0.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB_Master command port among NUM_REQ requesters.
// One command in flight at a time: IDLE -> ISSUE (transfer strobe) -> WAIT (for ready).
module apb_master_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     done,
  output logic [32*NUM_REQ-1:0]  req_rdata,
  output logic                   busy,
  output logic                   transfer,
  output logic                   write,
  output logic [31:0]            addr,
  output logic [31:0]            wdata,
  input  logic                   ready,
  input  logic [31:0]            rdata
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t               r_state, w_state_next;
  logic [IDX_W-1:0]     r_owner, r_last_grant, w_grant_idx;
  logic                 w_grant_valid;
  logic [NUM_REQ-1:0]   w_eligible, r_done;
  logic                 r_write;
  logic [31:0]          r_addr, r_wdata;
  logic [32*NUM_REQ-1:0] r_req_rdata;
  logic                 w_complete;
  logic [IDX_W-1:0]     v_idx;

  // A requester being told of completion this cycle must not be re-granted.
  assign w_eligible = req & ~r_done;
  assign w_complete = (r_state == S_WAIT) && ready;

  // Scan from farthest to nearest offset so the nearest eligible one wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    v_idx         = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      v_idx = IDX_W'((int'(r_last_grant) + off) % NUM_REQ);
      if (w_eligible[v_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = v_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_valid) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (PRESET) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_done       <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      // NOTE: the read-data bank is small and architecturally visible, so it is reset too.
      r_req_rdata  <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= '0;
      if ((r_state == S_IDLE) && w_grant_valid) begin
        r_owner <= w_grant_idx;
        r_write <= req_write[w_grant_idx];
        r_addr  <= req_addr[32*w_grant_idx +: 32];
        r_wdata <= req_wdata[32*w_grant_idx +: 32];
      end
      if (w_complete) begin
        r_done[r_owner] <= 1'b1;
        r_last_grant    <= r_owner;
        if (!r_write) r_req_rdata[32*r_owner +: 32] <= rdata;
      end
    end
  end

  assign done      = r_done;
  assign req_rdata = r_req_rdata;
  assign busy      = (r_state != S_IDLE);
  assign transfer  = (r_state == S_ISSUE);
  assign write     = r_write;
  assign addr      = r_addr;
  assign wdata     = r_wdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: a simple master/slave responder answers
// each transfer; expected commands and completions are queued and checked by a monitor.
module tb_apb_master_arbiter;

  localparam int NUM_REQ = 2;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  typedef struct {
    logic [NUM_REQ-1:0]    dn;
    logic [32*NUM_REQ-1:0] rd;
  } done_t;

  logic                   PCLK = 1'b0;
  logic                   PRESET;
  logic [NUM_REQ-1:0]     req, req_write;
  logic [32*NUM_REQ-1:0]  req_addr, req_wdata;
  logic [NUM_REQ-1:0]     done;
  logic [32*NUM_REQ-1:0]  req_rdata;
  logic                   busy, transfer, write;
  logic [31:0]            addr, wdata;
  logic                   ready;
  logic [31:0]            rdata;

  logic        r_ready_resp, stray_ready;
  logic [31:0] resp_rdata;
  int          ws_cycles;
  logic        c_w;
  logic [31:0] c_a, c_d;
  int          c_ws;
  logic [31:0] mem [logic [31:0]];

  cmd_t  exp_cmd[$];
  done_t exp_done[$];
  int    tests = 0;
  int    fails = 0;

  apb_master_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .req_rdata(req_rdata), .busy(busy),
    .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata)
  );

  always #5 PCLK = ~PCLK;

  assign ready = r_ready_resp | stray_ready;
  assign rdata = resp_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Master/slave responder: ready arrives c_ws cycles into WAIT.
  initial begin
    r_ready_resp = 1'b0;
    resp_rdata   = 32'hBAD0_BAD0;
    forever begin
      @(posedge PCLK); #1;
      if (transfer && !PRESET) begin
        c_w = write; c_a = addr; c_d = wdata; c_ws = ws_cycles;
        @(posedge PCLK); #1;
        repeat (c_ws) begin @(posedge PCLK); #1; end
        if (c_w) mem[c_a] = c_d;
        resp_rdata   = c_w ? 32'h0 : (mem.exists(c_a) ? mem[c_a] : 32'h0);
        r_ready_resp = 1'b1;
        @(posedge PCLK); #1;
        r_ready_resp = 1'b0;
        resp_rdata   = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transfer or a completion.
  initial begin
    cmd_t  ec;
    done_t ed;
    forever begin
      @(negedge PCLK);
      if (transfer) begin
        if (exp_cmd.size() == 0) check("spurious_transfer", 64'(transfer), 64'd0);
        else begin
          ec = exp_cmd.pop_front();
          check("cmd_write", 64'(write), 64'(ec.w));
          check("cmd_addr",  64'(addr),  64'(ec.a));
          check("cmd_wdata", 64'(wdata), 64'(ec.d));
        end
      end
      if (done != '0) begin
        if (exp_done.size() == 0) check("spurious_done", 64'(done), 64'd0);
        else begin
          ed = exp_done.pop_front();
          check("done_vec",  64'(done),      64'(ed.dn));
          check("req_rdata", 64'(req_rdata), 64'(ed.rd));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i]       = w;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.w = w; c.a = a; c.d = d;
    exp_cmd.push_back(c);
  endtask

  task automatic push_done(input logic [NUM_REQ-1:0] dn, input logic [32*NUM_REQ-1:0] rd);
    done_t e;
    e.dn = dn; e.rd = rd;
    exp_done.push_back(e);
  endtask

  task automatic wait_dones(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 300) begin
      @(negedge PCLK);
      cyc++;
      if (done != '0) seen++;
    end
    if (seen < n) check("done_timeout", 64'(seen), 64'(n));
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_cmd.size() + exp_done.size()) != 0 && cyc < 300) begin
      @(negedge PCLK);
      cyc++;
    end
    if ((exp_cmd.size() + exp_done.size()) != 0)
      check("drain_timeout", 64'(exp_cmd.size() + exp_done.size()), 64'd0);
    @(negedge PCLK);
  endtask

  task automatic wait_busy();
    int cyc = 0;
    while (!busy && cyc < 50) begin
      @(negedge PCLK);
      cyc++;
    end
    if (!busy) check("busy_timeout", 64'(busy), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_transfer"},  64'(transfer),  64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_write"},     64'(write),     64'd0);
    check({tag, "_addr"},      64'(addr),      64'd0);
    check({tag, "_wdata"},     64'(wdata),     64'd0);
    check({tag, "_req_rdata"}, 64'(req_rdata), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    req = 2'b11; req_write = '0; req_addr = '0; req_wdata = '0;
    stray_ready = 1'b0;
    ws_cycles = 0;
    set_req(0, 1'b1, 32'h1111_1111, 32'h2222_2222);
    set_req(1, 1'b0, 32'h3333_3333, 32'h4444_4444);

    // Reset held with both requests asserted.
    repeat (2) begin
      @(negedge PCLK);
      check_reset_values("reset");
    end
    req = '0;
    PRESET = 1'b0;
    @(negedge PCLK);

    // Single write then read-back through requester 0.
    set_req(0, 1'b1, 32'h1000_0004, 32'd2);
    push_cmd(1'b1, 32'h1000_0004, 32'd2);
    push_done(2'b01, 64'h0);
    req = 2'b01;
    wait_dones(1);
    req = '0;
    wait_drain();

    set_req(0, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF);
    push_cmd(1'b0, 32'h1000_0004, 32'hDEAD_BEEF);
    push_done(2'b01, {32'd0, 32'd2});
    req = 2'b01;
    wait_dones(1);
    req = '0;
    wait_drain();

    // Cross-slave write then read through requester 1; slice 0 unchanged.
    set_req(1, 1'b1, 32'h1000_3000, 32'd100);
    push_cmd(1'b1, 32'h1000_3000, 32'd100);
    push_done(2'b10, {32'd0, 32'd2});
    req = 2'b10;
    wait_dones(1);
    req = '0;
    wait_drain();

    set_req(1, 1'b0, 32'h1000_3000, 32'd0);
    push_cmd(1'b0, 32'h1000_3000, 32'd0);
    push_done(2'b10, {32'd100, 32'd2});
    req = 2'b10;
    wait_dones(1);
    req = '0;
    wait_drain();

    // Round-robin with both held; last owner was 1 so order is 0,1,0,1.
    set_req(0, 1'b1, 32'h1000_0000, 32'd1);
    set_req(1, 1'b1, 32'h1000_1000, 32'd11);
    for (int k = 0; k < 2; k++) begin
      push_cmd(1'b1, 32'h1000_0000, 32'd1);
      push_cmd(1'b1, 32'h1000_1000, 32'd11);
      push_done(2'b01, {32'd100, 32'd2});
      push_done(2'b10, {32'd100, 32'd2});
    end
    req = 2'b11;
    wait_dones(4);
    req = '0;
    wait_drain();

    // Stray ready in IDLE.
    stray_ready = 1'b1;
    repeat (4) begin
      @(negedge PCLK);
      check("stray_done", 64'(done), 64'd0);
      check("stray_busy", 64'(busy), 64'd0);
    end
    stray_ready = 1'b0;
    @(negedge PCLK);

    // Five slave wait states.
    ws_cycles = 5;
    set_req(0, 1'b0, 32'h1000_0000, 32'd1);
    push_cmd(1'b0, 32'h1000_0000, 32'd1);
    push_done(2'b01, {32'd100, 32'd1});
    req = 2'b01;
    wait_busy();
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      check("ws_busy",     64'(busy),     64'd1);
      check("ws_transfer", 64'(transfer), 64'd0);
    end
    wait_dones(1);
    check("ws_idle_at_done", 64'(busy), 64'd0);
    req = '0;
    wait_drain();

    // Reset mid-WAIT: no done, outputs to reset values, requester 0 wins next.
    ws_cycles = 8;
    set_req(1, 1'b0, 32'h1000_1000, 32'd0);
    push_cmd(1'b0, 32'h1000_1000, 32'd0);
    req = 2'b10;
    wait_busy();
    repeat (2) @(negedge PCLK);
    check("pre_reset_busy", 64'(busy), 64'd1);
    PRESET = 1'b1;
    req = '0;
    @(negedge PCLK);
    check_reset_values("midreset");
    PRESET = 1'b0;
    repeat (15) @(negedge PCLK);
    ws_cycles = 0;

    set_req(0, 1'b0, 32'h1000_0004, 32'd0);
    set_req(1, 1'b0, 32'h1000_3000, 32'd0);
    push_cmd(1'b0, 32'h1000_0004, 32'd0);
    push_cmd(1'b0, 32'h1000_3000, 32'd0);
    push_done(2'b01, {32'd0, 32'd2});
    push_done(2'b10, {32'd100, 32'd2});
    req = 2'b11;
    wait_dones(2);
    req = '0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
